// File: rtl/uart_rx_115200.sv
// uart_rx_115200 -- 8N1 UART receive framer, 115200 baud on the 50 MHz clock.
// Works with the shared baud generator: bps_start requests mid-bit bps_clk
// pulses, and the synchronised line is sampled on those pulses. A good frame
// updates rx_data with a one-cycle rx_valid strobe. A frame whose stop bit
// is low gives a one-cycle frame_err strobe and leaves rx_data unchanged.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge; bps_clk ignored
// START | start edge seen, waiting for mid-start-bit sample to confirm
// DATA  | shifting in DATA_BITS data bits, LSB first
// STOP  | waiting for the mid-stop-bit sample, then report and return

module uart_rx_115200 #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 bps_clk,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic rx_m, rx_s, rx_d;
  logic fall;

  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] rx_data_nxt;
  logic                 rx_valid_nxt;
  logic                 frame_err_nxt;
  logic                 bps_start_nxt;

  // Two-flop synchroniser plus edge-detect delay; all reset high so that
  // leaving reset with the line idle never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  // State register and all datapath/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      bps_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
      bps_start <= bps_start_nxt;
    end
  end

  // Next-state and next-register logic; the strobes default low so they
  // last exactly one cycle.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    bps_start_nxt = bps_start;

    unique case (state)
      S_IDLE: begin
        bps_start_nxt = 1'b0;
        if (fall) begin
          state_nxt     = S_START;
          bps_start_nxt = 1'b1;
        end
      end

      S_START: begin
        if (bps_clk) begin
          if (!rx_s) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = '0;
          end else begin
            // Start bit was not low at mid-bit: treat as a glitch and drop
            // the frame silently.
            state_nxt     = S_IDLE;
            bps_start_nxt = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (bps_clk) begin
          shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (bps_clk) begin
          if (rx_s) begin
            rx_data_nxt  = shreg;
            rx_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
          state_nxt     = S_IDLE;
          bps_start_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt     = S_IDLE;
        bps_start_nxt = 1'b0;
      end
    endcase
  end

  // busy changes on the same edges as bps_start, so both drop together
  // with the result strobe.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_115200.sv
// tb_uart_rx_115200 -- directed bench for the UART receive framer, with a
// behavioural model of the shared baud generator (434 clk/bit, first pulse
// half a bit after bps_start rises, counter held clear while bps_start low).

module tb_uart_rx_115200;

  localparam int BIT_CLK  = 434;
  localparam int HALF_CLK = 217;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       bps_clk;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  logic       bps_inj;
  int         bps_cnt;

  int n_checks;
  int n_fail;

  // monitor state
  int         cyc;
  int         n_valid;
  int         n_ferr;
  logic [7:0] last_data;
  logic [7:0] prev_data;
  int         t_valid;
  int         t_valid_prev;
  int         t_bps_rise;
  int         t_bps_fall;
  logic       bps_start_q;
  int         t_fall;

  uart_rx_115200 #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .bps_clk   (bps_clk),
    .bps_start (bps_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Baud generator model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          bps_cnt <= 0;
    else if (!bps_start) bps_cnt <= 0;
    else if (bps_cnt == BIT_CLK - 1) bps_cnt <= 0;
    else                 bps_cnt <= bps_cnt + 1;
  end

  assign bps_clk = (bps_start && bps_cnt == HALF_CLK) || bps_inj;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Observe outputs on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    bps_start_q <= bps_start;
    if (bps_start && !bps_start_q) t_bps_rise <= cyc;
    if (!bps_start && bps_start_q) t_bps_fall <= cyc;
    if (rx_valid) begin
      n_valid      <= n_valid + 1;
      prev_data    <= last_data;
      last_data    <= rx_data;
      t_valid_prev <= t_valid;
      t_valid      <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_valid || frame_err) begin
      n_checks++;
      if (rx_valid && frame_err) begin
        n_fail++;
        $display("FAIL strobe_excl: rx_valid=%b frame_err=%b, expected not both", rx_valid, frame_err);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one bit for a full bit time; optionally pull the line low briefly
  // near the start of the bit, well away from the mid-bit sample.
  task automatic drive_bit(input logic b, input bit glitch);
    rx = b;
    if (glitch) begin
      wait_clk(50);
      rx = 1'b0;
      wait_clk(20);
      rx = b;
      wait_clk(BIT_CLK - 70);
    end else begin
      wait_clk(BIT_CLK);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int glitch_bit);
    t_fall = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == glitch_bit));
    drive_bit(stop, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, f0;
    logic [7:0] d0;
    bit seen;

    n_checks = 0; n_fail = 0;
    cyc = 0; n_valid = 0; n_ferr = 0;
    last_data = 8'h00; prev_data = 8'h00;
    t_valid = 0; t_valid_prev = 0; t_bps_rise = 0; t_bps_fall = 0;
    bps_start_q = 1'b0; t_fall = 0;
    bps_inj = 1'b0;
    rx = 1'b1;
    rst_n = 1'b0;

    vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[4] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[5] = '{8'hC6, 1'b0, 0, 1, 8'h01};
    vecs[6] = '{8'h3C, 1'b1, 1, 0, 8'h3C};

    // Reset state
    wait_clk(5);
    @(negedge clk);
    check("rst_bps_start", bps_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    wait_clk(20);
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    // Single byte with latency and frame duration
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h55, 1'b1, -1);
    wait_clk(20);
    @(negedge clk);
    check("single_valid_cnt", n_valid - v0, 1);
    check("single_ferr_cnt", n_ferr - f0, 0);
    check("single_data", last_data, 8'h55);
    // nominal 4124 +-4, plus up to 4 cycles of bench-side measurement offset
    check_range("single_latency", t_valid - t_fall, 4120, 4132);
    check_range("single_bps_start_len", t_bps_fall - t_bps_rise, 4120, 4128);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      v0 = n_valid; f0 = n_ferr;
      send_byte(vecs[i].data, vecs[i].stop, -1);
      if (!vecs[i].stop) begin
        rx = 1'b1;
        wait_clk(1000);
      end
      wait_clk(20);
      @(negedge clk);
      check($sformatf("vec%0d_valid_cnt", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr_cnt", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
    end

    // Back-to-back frames, zero idle gap
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'hA3, 1'b1, -1);
    send_byte(8'h0F, 1'b1, -1);
    wait_clk(20);
    @(negedge clk);
    check("b2b_valid_cnt", n_valid - v0, 2);
    check("b2b_first", prev_data, 8'hA3);
    check("b2b_second", last_data, 8'h0F);
    check_range("b2b_spacing", t_valid - t_valid_prev, 4335, 4345);

    // Glitch start
    v0 = n_valid; f0 = n_ferr; d0 = rx_data;
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bps_start) seen = 1'b1;
    end
    wait_clk(1);
    rx = 1'b1;
    wait_clk(400);
    @(negedge clk);
    check("glitch_bps_rose", seen, 1'b1);
    check_range("glitch_bps_len", t_bps_fall - t_bps_rise, 215, 221);
    check("glitch_bps_start", bps_start, 1'b0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_ferr_cnt", n_ferr - f0, 0);
    check("glitch_rx_data", rx_data, d0);

    // Framing error, then a break: no new frame while the line stays low
    v0 = n_valid; f0 = n_ferr; d0 = rx_data;
    send_byte(8'hC6, 1'b0, -1);
    wait_clk(1500);
    @(negedge clk);
    check("ferr_ferr_cnt", n_ferr - f0, 1);
    check("ferr_valid_cnt", n_valid - v0, 0);
    check("ferr_rx_data", rx_data, d0);
    check("break_busy", busy, 1'b0);
    rx = 1'b1;
    wait_clk(600);
    send_byte(8'h3C, 1'b1, -1);
    wait_clk(20);
    @(negedge clk);
    check("after_break_valid_cnt", n_valid - v0, 1);
    check("after_break_data", rx_data, 8'h3C);

    // Reset during data bit 4 of 0xFF
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    rx = 1'b1;
    wait_clk(200);
    rst_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    check("midrst_bps_start", bps_start, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(BIT_CLK * 4 + 5000);
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h81, 1'b1, -1);
    wait_clk(20);
    @(negedge clk);
    check("midrst_next_valid_cnt", n_valid - v0, 1);
    check("midrst_next_data", rx_data, 8'h81);

    // Idle robustness: stray bps_clk pulses, and edges inside a frame
    v0 = n_valid; f0 = n_ferr;
    for (int i = 0; i < 4; i++) begin
      bps_inj = 1'b1;
      wait_clk(1);
      bps_inj = 1'b0;
      wait_clk(30);
    end
    @(negedge clk);
    check("idle_inj_busy", busy, 1'b0);
    check("idle_inj_bps_start", bps_start, 1'b0);
    check("idle_inj_rx_data", rx_data, 8'h81);
    send_byte(8'h5A, 1'b1, 1);
    wait_clk(20);
    @(negedge clk);
    check("edge_in_frame_valid_cnt", n_valid - v0, 1);
    check("edge_in_frame_ferr_cnt", n_ferr - f0, 0);
    check("edge_in_frame_data", rx_data, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #4000000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
